// File: rtl/btn_to_dir_pkg.sv
// Shared game-input definitions: direction bit order, encoder FSM states and
// small vector helpers used by the button encoder and the LED decoder.
package btn_to_dir_pkg;

  localparam int unsigned NUM_DIRS = 4;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_PRESSED  = 2'd1,
    ST_CONFLICT = 2'd2
  } dir_state_e;

  // Only meaningful for a one-hot input; multi-bit vectors are filtered out by
  // the FSM before the encoded value is ever used.
  function automatic logic [1:0] onehot_to_dir(input logic [NUM_DIRS-1:0] v);
    logic [1:0] d;
    d[0] = v[DIR_RIGHT] | v[DIR_LEFT];
    d[1] = v[DIR_DOWN]  | v[DIR_LEFT];
    return d;
  endfunction

  function automatic logic [2:0] count_ones(input logic [NUM_DIRS-1:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < NUM_DIRS; i++) begin
      n = n + 3'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/btn_to_dir_debounce_vec.sv
// Vector debouncer: two-flop synchroniser, one-cycle history register and a
// saturating stability counter; the whole vector must hold for the full window.
module btn_to_dir_debounce_vec #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] stable
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] s3_q, s3_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d     = din;
    s2_d     = s1_q;
    s3_d     = s2_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (s2_q != s3_q) begin
      cnt_d = '0;
    end else begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        stable_d = s2_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/btn_to_dir.sv
// Debounced direction-button encoder: settles the raw button vector, then
// classifies it as released / single press / conflict with registered outputs.
module btn_to_dir
  import btn_to_dir_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_DIRS-1:0] buttons,
  output logic [1:0]          num,
  output logic                pressed,
  output logic                press_pulse,
  output logic                conflict
);

  logic [NUM_DIRS-1:0] stable;
  logic [1:0]          dir;
  dir_state_e          state_q, state_d;
  logic [1:0]          num_q, num_d;
  logic                pressed_q, pressed_d;
  logic                pulse_q, pulse_d;
  logic                conflict_q, conflict_d;

  btn_to_dir_debounce_vec #(
    .WIDTH           (NUM_DIRS),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .din    (buttons),
    .stable (stable)
  );

  assign dir = onehot_to_dir(stable);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RELEASED;
      num_q      <= DIR_UP;
      pressed_q  <= 1'b0;
      pulse_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      pressed_q  <= pressed_d;
      pulse_q    <= pulse_d;
      conflict_q <= conflict_d;
    end
  end

  always_comb begin
    state_d = ST_CONFLICT;
    case (count_ones(stable))
      3'd0:    state_d = ST_RELEASED;
      3'd1:    state_d = ST_PRESSED;
      default: state_d = ST_CONFLICT;
    endcase
  end

  // Outputs are computed from the upcoming state so they land in the same
  // register stage as the state itself; num holds outside PRESSED.
  always_comb begin
    num_d      = num_q;
    pressed_d  = 1'b0;
    pulse_d    = 1'b0;
    conflict_d = 1'b0;
    case (state_d)
      ST_PRESSED: begin
        num_d     = dir;
        pressed_d = 1'b1;
        pulse_d   = (state_q != ST_PRESSED) || (dir != num_q);
      end
      ST_CONFLICT: begin
        conflict_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign num         = num_q;
  assign pressed     = pressed_q;
  assign press_pulse = pulse_q;
  assign conflict    = conflict_q;

endmodule

// File: doc/btn_to_dir.md
# btn_to_dir

Debounced direction-button encoder for the player input path. Synchronises and debounces four active-high direction buttons, then encodes the settled one-hot button vector into a 2-bit direction index plus a pressed flag. It is the inverse of the LED one-hot decoder, and its `num`/`pressed` outputs feed the player-movement logic and the LED indicator directly.

## Interface
- `DEBOUNCE_CYCLES`, default 500000, is the number of consecutive stable cycles required before a button vector is accepted. Legal values are ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`, is the debounce counter width.
- `clk`  in  1  is the system clock. It is the only clock.
- `rst`  in  1  is the reset: synchronous, active-high.
- `buttons`  in  4  is the raw, asynchronous button inputs. Bit i set means direction i is held (0 = up, 1 = right, 2 = down, 3 = left).
- `num`  out  2  is the encoded direction index of the accepted press. It holds its last valid value when no valid press is active.
- `pressed`  out  1  is high while exactly one button is accepted as held.
- `press_pulse`  out  1  is a one-cycle strobe on each new accepted press, or on a direction change while pressed.
- `conflict`  out  1  is high while the accepted vector has two or more bits set.

## Operation
- **Synchroniser:** two-flop stage `s1 → s2` on all 4 bits, followed by a history register `s3` that holds `s2` delayed by one cycle.
- **Debounce counter `cnt`:**
  - If `s2 != s3`, then `cnt <= 0`.
  - Otherwise, if `cnt != DEBOUNCE_CYCLES-1`, then `cnt <= cnt+1`. The counter saturates and does not wrap.
- **Stable register `stable[3:0]`:** loads `s2` when `s2 == s3` and `cnt == DEBOUNCE_CYCLES-1`. Any glitch shorter than the window resets `cnt` and leaves `stable` unchanged.
- **Classification of `stable`, registered into the output FSM:**
  - **RELEASED:** `stable == 0`. Outputs are `pressed=0`, `conflict=0`, and `num` held.
  - **PRESSED:** `stable` is one-hot. Outputs are `pressed=1`, `num = index of set bit`, `conflict=0`.
  - **CONFLICT:** two or more bits set. Outputs are `pressed=0`, `conflict=1`, and `num` held. A multi-button press is never encoded.
- **FSM transitions:** any state can move to any state. The next state is purely a function of `stable` and is evaluated every cycle.
- **`press_pulse` is asserted for exactly one cycle when:**
  - the FSM enters PRESSED from RELEASED or CONFLICT, or
  - the FSM stays in PRESSED and `num` changes. This is possible only if `stable` moves directly between two one-hot values.
- **Reset:** `rst` clears `s1`, `s2`, `s3`, `stable` and `cnt` to 0, and puts the FSM in RELEASED. Reset outputs are `num=0`, `pressed=0`, `press_pulse=0`, `conflict=0`.
- **Reset mid-debounce:** the in-progress count is discarded. A button still held after reset must re-qualify for the full window.

## Timing
- Edge 0 is the first rising edge that samples a new `buttons` value into `s1`, with that value then held constant.
  - Edge 1: `s2` updates.
  - Edge 2: `cnt` is cleared.
  - Edge `DEBOUNCE_CYCLES+1`: `cnt` reaches `DEBOUNCE_CYCLES-1`.
  - Edge `DEBOUNCE_CYCLES+2`: `stable` loads.
  - Edge `DEBOUNCE_CYCLES+3`: `num`, `pressed`, `conflict` and `press_pulse` update.
- Input-to-output latency is exactly `DEBOUNCE_CYCLES+3` cycles. The same latency applies to release, conflict and direction change.
- `press_pulse` is high during the single cycle after edge `DEBOUNCE_CYCLES+3`, and low on all other cycles.
- Every output is a register output. There is no combinational path from `buttons`.
- A bounce that toggles the input at any point during the window restarts the latency count from the last toggle.

## Structure
- The shared game package holds:
  - direction constants `DIR_UP=0`, `DIR_RIGHT=1`, `DIR_DOWN=2`, `DIR_LEFT=3`, so that the decoder and this block agree on bit order;
  - the FSM state typedef (RELEASED, PRESSED, CONFLICT).
- One natural sub-module is `debounce_vec`. It contains the synchroniser, history register, counter and `stable` register, is parameterised by width and `DEBOUNCE_CYCLES`, and is reusable for the start/pause buttons. The encoder and FSM stay in `btn_to_dir`.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES=4`.
- **Clean press/release:** `buttons=4'b0100` from edge 0, held 20 cycles, then `0`.
  - At edge 7: `num=2`, `pressed=1`, and `press_pulse` is high for 1 cycle.
  - Seven edges after the release sample: `pressed=0` and `num` stays 2.
- **Bounce rejection:** toggle `buttons` between `0001` and `0000` every 2 cycles for 12 cycles, then hold `0001`.
  - `pressed` stays 0 throughout the bouncing.
  - `pressed=1` and `num=0` exactly 7 edges after the final toggle.
- **Conflict:** hold `0011` for 12 cycles.
  - `conflict=1`, `pressed=0`, `press_pulse` never asserted, and `num` keeps its prior value.
  - Then drop to `0010`: 7 edges later `conflict=0`, `pressed=1`, `num=1`, and one `press_pulse`.
- **Direct direction change:** `1000` held until accepted, then switched straight to `0100`.
  - `num` goes 3 → 2 with `pressed` staying 1.
  - Exactly two `press_pulse` strobes in total.
- **Reset mid-operation:** hold `0001` and assert `rst` for 1 cycle at edge 4.
  - All outputs are 0 after the reset edge.
  - With `0001` still held, `pressed=1` occurs exactly 7 edges after the first post-reset sampling edge.
- **Short glitch:** a 3-cycle pulse of `0100`, shorter than the window, produces no output change.
